// File: rtl/case_2_prod_acc.sv
// Accumulates a run of signed multiplier products into a saturating or wrapping sum.
// Runs are sequenced by an ap_start/ap_ready/ap_done/ap_idle block handshake.
module case_2_prod_acc #(
    parameter int unsigned DIN_W = 5,
    parameter int unsigned ACC_W = 12,
    parameter int unsigned CNT_W = 8,
    parameter bit          SAT   = 1'b1
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic             ap_start,
    output logic             ap_ready,
    output logic             ap_idle,
    output logic             ap_done,
    input  logic [CNT_W-1:0] len,
    input  logic [DIN_W-1:0] prod_din,
    input  logic             prod_vld,
    output logic             prod_ack,
    output logic [ACC_W-1:0] sum_dout,
    output logic             sum_vld,
    input  logic             sum_ack,
    output logic             ovf
);

    typedef enum logic [1:0] {StIdle, StAcc, StOut} state_e;

    localparam logic [ACC_W-1:0] AccMax = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] AccMin = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           state_q;
    logic [ACC_W-1:0] acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] len_q;
    logic             ovf_q;

    logic [ACC_W:0]   prod_ext;
    logic [ACC_W:0]   sum_wide;
    logic             sum_ovf;
    logic [ACC_W-1:0] acc_next;
    logic             last_beat;

    // One guard bit above the accumulator exposes overflow as a top-two-bit mismatch.
    always_comb begin
        prod_ext = {{(ACC_W + 1 - DIN_W){prod_din[DIN_W-1]}}, prod_din};
        sum_wide = {acc_q[ACC_W-1], acc_q} + prod_ext;
        sum_ovf  = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
        acc_next = sum_wide[ACC_W-1:0];
        if (SAT && sum_ovf) begin
            acc_next = sum_wide[ACC_W] ? AccMin : AccMax;
        end
        last_beat = (cnt_q == (len_q - CntOne));
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state_q <= StIdle;
            acc_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (ap_start) begin
                        len_q   <= len;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        ovf_q   <= 1'b0;
                        state_q <= (len == '0) ? StOut : StAcc;
                    end
                end
                StAcc: begin
                    if (prod_vld) begin
                        acc_q <= acc_next;
                        cnt_q <= cnt_q + CntOne;
                        ovf_q <= ovf_q | sum_ovf;
                        if (last_beat) begin
                            state_q <= StOut;
                        end
                    end
                end
                StOut: begin
                    if (sum_ack) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        ap_idle  = (state_q == StIdle);
        ap_ready = (state_q == StIdle) && ap_start;
        prod_ack = (state_q == StAcc);
        sum_vld  = (state_q == StOut);
        ap_done  = (state_q == StOut) && sum_ack;
        sum_dout = acc_q;
        ovf      = ovf_q;
    end

endmodule

// File: tb/tb_case_2_prod_acc.sv
// Randomized bench for case_2_prod_acc: saturating and wrapping instances share stimulus
// and are compared against an integer-arithmetic model of each run.
module tb_case_2_prod_acc;

    logic       clk;
    logic       rst_n;
    logic       ap_start;
    logic [7:0] len;
    logic [4:0] prod_din;
    logic       prod_vld;
    logic       sum_ack;

    logic        rdy_s, idle_s, done_s, pack_s, svld_s, ovf_s;
    logic [11:0] sum_s;
    logic        rdy_w, idle_w, done_w, pack_w, svld_w, ovf_w;
    logic [11:0] sum_w;

    int n_checks;
    int n_pass;
    int beats[$];

    case_2_prod_acc #(.DIN_W(5), .ACC_W(12), .CNT_W(8), .SAT(1'b1)) u_sat (
        .ap_clk(clk), .ap_rst_n(rst_n), .ap_start(ap_start), .ap_ready(rdy_s),
        .ap_idle(idle_s), .ap_done(done_s), .len(len), .prod_din(prod_din),
        .prod_vld(prod_vld), .prod_ack(pack_s), .sum_dout(sum_s), .sum_vld(svld_s),
        .sum_ack(sum_ack), .ovf(ovf_s)
    );

    case_2_prod_acc #(.DIN_W(5), .ACC_W(12), .CNT_W(8), .SAT(1'b0)) u_wrap (
        .ap_clk(clk), .ap_rst_n(rst_n), .ap_start(ap_start), .ap_ready(rdy_w),
        .ap_idle(idle_w), .ap_done(done_w), .len(len), .prod_din(prod_din),
        .prod_vld(prod_vld), .prod_ack(pack_w), .sum_dout(sum_w), .sum_vld(svld_w),
        .sum_ack(sum_ack), .ovf(ovf_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    // Reference: plain integer sums with clamp or modular wrap into [-2048, 2047].
    task automatic model(output int s_sat, output int s_wrap, output int o_sat,
                         output int o_wrap);
        int t;
        s_sat = 0; s_wrap = 0; o_sat = 0; o_wrap = 0;
        foreach (beats[i]) begin
            t = s_sat + beats[i];
            if (t > 2047) begin t = 2047; o_sat = 1; end
            if (t < -2048) begin t = -2048; o_sat = 1; end
            s_sat = t;
            t = s_wrap + beats[i];
            if (t > 2047) begin t -= 4096; o_wrap = 1; end
            if (t < -2048) begin t += 4096; o_wrap = 1; end
            s_wrap = t;
        end
    endtask

    task automatic run_case(input int n, input bit gaps, input int ack_wait);
        int          e_sat, e_wrap, e_os, e_ow;
        int          idx, stalls, edges, budget;
        logic [31:0] bv;
        model(e_sat, e_wrap, e_os, e_ow);
        @(posedge clk); #1;
        ap_start = 1'b1;
        len      = n[7:0];
        #1;
        check_eq("start_ready", int'(rdy_s), 1);
        check_eq("start_idle", int'(idle_s), 1);
        check_eq("idle_no_ack", int'(pack_s), 0);
        @(posedge clk); #1;
        ap_start = 1'b0;
        edges  = 1;
        idx    = 0;
        stalls = 0;
        budget = 4 * n + 50;
        while (idx < n && budget > 0) begin
            bv       = beats[idx];
            prod_din = bv[4:0];
            prod_vld = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            ap_start = ($urandom_range(0, 3) == 0);
            #1;
            check_eq("acc_prod_ack", int'(pack_s), 1);
            check_eq("acc_no_sum_vld", int'(svld_s), 0);
            check_eq("acc_ready_ignored", int'(rdy_s), 0);
            @(posedge clk);
            edges++;
            budget--;
            if (prod_vld) idx++;
            else stalls++;
            #1;
        end
        check_eq("beat_budget", idx, n);
        // Offer a surplus beat; it must not be taken.
        prod_vld = 1'b1;
        prod_din = 5'd7;
        ap_start = 1'b0;
        #1;
        check_eq("sum_vld_rise", int'(svld_s), 1);
        check_eq("latency_edges", edges, n + stalls + 1);
        check_eq("extra_beat_not_acked", int'(pack_s), 0);
        for (int k = 0; k < ack_wait; k++) begin
            ap_start = ($urandom_range(0, 1) == 1);
            #1;
            check_eq("hold_vld", int'(svld_s), 1);
            check_eq("hold_sum", int'($signed(sum_s)), e_sat);
            check_eq("hold_done", int'(done_s), 0);
            check_eq("hold_ready_ignored", int'(rdy_s), 0);
            check_eq("hold_prod_ack", int'(pack_s), 0);
            @(posedge clk); #1;
        end
        ap_start = 1'b0;
        sum_ack  = 1'b1;
        #1;
        check_eq("done_pulse", int'(done_s), 1);
        check_eq("sum_sat", int'($signed(sum_s)), e_sat);
        check_eq("sum_wrap", int'($signed(sum_w)), e_wrap);
        check_eq("ovf_sat", int'(ovf_s), e_os);
        check_eq("ovf_wrap", int'(ovf_w), e_ow);
        check_eq("wrap_done", int'(done_w), 1);
        @(posedge clk); #1;
        sum_ack  = 1'b0;
        prod_vld = 1'b0;
        #1;
        check_eq("back_idle", int'(idle_s), 1);
        check_eq("done_one_cycle", int'(done_s), 0);
        check_eq("vld_dropped", int'(svld_s), 0);
    endtask

    task automatic rand_beats(input int n);
        beats.delete();
        for (int i = 0; i < n; i++) beats.push_back(int'($urandom_range(0, 31)) - 16);
    endtask

    initial begin
        logic [31:0] bv;
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        ap_start = 1'b0;
        len      = '0;
        prod_din = '0;
        prod_vld = 1'b0;
        sum_ack  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_idle", int'(idle_s), 1);
        check_eq("rst_prod_ack", int'(pack_s), 0);
        check_eq("rst_sum_vld", int'(svld_s), 0);
        check_eq("rst_done", int'(done_s), 0);
        check_eq("rst_ready", int'(rdy_s), 0);
        check_eq("rst_ovf", int'(ovf_s), 0);
        check_eq("rst_sum", int'(sum_s), 0);
        rst_n = 1'b1;

        beats = '{3, -2, 7, 1};
        run_case(4, 1'b0, 0);
        beats.delete();
        run_case(0, 1'b0, 2);
        beats.delete();
        for (int i = 0; i < 137; i++) beats.push_back(15);
        run_case(137, 1'b0, 1);
        beats = '{5, -9, 11};
        run_case(3, 1'b1, 5);
        rand_beats(255);
        run_case(255, 1'b1, 1);
        for (int r = 0; r < 12; r++) begin
            int n;
            n = int'($urandom_range(1, 24));
            rand_beats(n);
            run_case(n, 1'($urandom_range(0, 1)), int'($urandom_range(0, 4)));
        end

        // Abort a run after two of four beats.
        @(posedge clk); #1;
        ap_start = 1'b1;
        len      = 8'd4;
        @(posedge clk); #1;
        ap_start = 1'b0;
        prod_vld = 1'b1;
        prod_din = 5'd9;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n    = 1'b1;
        prod_vld = 1'b0;
        #1;
        check_eq("abort_idle", int'(idle_s), 1);
        check_eq("abort_sum_vld", int'(svld_s), 0);
        check_eq("abort_done", int'(done_s), 0);
        check_eq("abort_prod_ack", int'(pack_s), 0);
        check_eq("abort_ovf", int'(ovf_s), 0);
        bv = 32'd0;
        beats = '{-16, -16};
        run_case(2, 1'b0, 0);
        bv = 32'(-32);
        check_eq("post_abort_sum", int'($signed(sum_s)), int'($signed(bv)));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
